// File: rtl/ks_pkg.sv
// ============================================================================
// Package     : ks_pkg
// Description : Shared definitions for the Karplus-Strong string voice:
//               default widths and depth, the sequencer state type and the
//               delay-length clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ks_pkg;

  localparam int KS_SAMPLE_W = 16;
  localparam int KS_MAX_LEN  = 1024;
  localparam int KS_LEN_W    = 10;

  // Every active tick runs WAIT -> ACC -> (MUL) -> UPD -> WAIT.
  typedef enum logic [2:0] {
    IDLE,
    FILL_WAIT,
    FILL_ACC,
    FILL_UPD,
    PLAY_WAIT,
    PLAY_ACC,
    PLAY_UPD
`ifdef KS_DECAY_EN
    ,
    PLAY_MUL
`endif
  } ks_state_e;

  // Delay length is kept inside [2, max_len]; a length of 1 would make the
  // averaging filter read the sample it is about to overwrite.
  function automatic int clamp_len(input int p, input int max_len);
    if (p < 2)
      return 2;
    else if (p > max_len)
      return max_len;
    else
      return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ks_delay_ram.sv
// ============================================================================
// Module      : ks_delay_ram
// Description : Simple dual-port delay-line memory, DEPTH x DATA_W, one write
//               port and one synchronous (1-cycle) read port. Contents are
//               not reset so the array maps onto block RAM.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address
//               o_rdata  - registered read data (mem[i_raddr] of last cycle)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ks_delay_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ks_string_synth.sv
// ============================================================================
// Module      : ks_string_synth
// Description : Karplus-Strong plucked-string voice. A pluck fills a circular
//               delay line with `period` noise samples (each one is also
//               emitted), after which the line is recirculated through a
//               two-tap averaging low-pass filter, one sample per tick.
// Option      : KS_DECAY_EN - adds the `decay` port (unsigned Q0.16 gain
//               applied to every recirculated sample) and one multiply stage
//               in the play path.
// Ports       : clk          - system clock
//               reset_n      - asynchronous active-low reset
//               noise_in     - signed noise sample
//               sample_tick  - single-cycle audio-rate strobe
//               pluck        - start/restart request (wins over stop)
//               stop         - stop request, output forced to 0
//               period       - delay length, sampled on pluck
//               decay        - (KS_DECAY_EN only) gain, sampled on pluck
//               sample_out   - current signed output sample
//               sample_valid - one-cycle pulse when sample_out updates
//               active       - high while filling or playing
//               overrun      - sticky: a tick arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ks_string_synth
  import ks_pkg::*;
#(
  parameter int SAMPLE_W = KS_SAMPLE_W,
  parameter int MAX_LEN  = KS_MAX_LEN,
  parameter int LEN_W    = KS_LEN_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [SAMPLE_W-1:0] noise_in,
  input  logic                       sample_tick,
  input  logic                       pluck,
  input  logic                       stop,
  input  logic [LEN_W:0]             period,
`ifdef KS_DECAY_EN
  input  logic [15:0]                decay,
`endif
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       active,
  output logic                       overrun
);

  ks_state_e                  r_state;
  logic [LEN_W-1:0]           r_idx;
  logic [LEN_W:0]             r_len;
  logic signed [SAMPLE_W-1:0] r_x;
  logic signed [SAMPLE_W-1:0] r_prev;
  logic signed [SAMPLE_W-1:0] r_out;
  logic                       r_valid;
  logic                       r_ovr;

  logic [SAMPLE_W-1:0]        w_rd_raw;
  logic signed [SAMPLE_W-1:0] w_rd;
  logic signed [SAMPLE_W:0]   w_sum;
  logic signed [SAMPLE_W-1:0] w_avg;
  logic                       w_last;
  logic                       w_busy;
  logic                       w_we;
  logic [SAMPLE_W-1:0]        w_wdata;

  assign w_rd = $signed(w_rd_raw);

  // One extra bit keeps the sum exact; the arithmetic shift floors toward
  // -inf and the halved value always fits back into SAMPLE_W bits.
  assign w_sum = {w_rd[SAMPLE_W-1], w_rd} + {r_prev[SAMPLE_W-1], r_prev};
  assign w_avg = SAMPLE_W'(w_sum >>> 1);

  assign w_last = ({1'b0, r_idx} == (r_len - (LEN_W+1)'(1)));

`ifdef KS_DECAY_EN
  logic signed [SAMPLE_W-1:0] r_avg;
  logic [15:0]                r_decay;
  logic signed [SAMPLE_W+16:0] w_prod;
  logic signed [SAMPLE_W-1:0] w_scaled;

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  assign w_prod   = (SAMPLE_W+17)'(r_avg) * $signed({{SAMPLE_W{1'b0}}, 1'b0, r_decay});
  assign w_scaled = SAMPLE_W'(w_prod >>> 16);

  assign w_busy  = (r_state == FILL_ACC) || (r_state == FILL_UPD) ||
                   (r_state == PLAY_ACC) || (r_state == PLAY_MUL) ||
                   (r_state == PLAY_UPD);
  assign w_we    = !pluck && !stop &&
                   ((r_state == FILL_ACC) || (r_state == PLAY_MUL));
  assign w_wdata = (r_state == FILL_ACC) ? r_x : w_scaled;
`else
  assign w_busy  = (r_state == FILL_ACC) || (r_state == FILL_UPD) ||
                   (r_state == PLAY_ACC) || (r_state == PLAY_UPD);
  // The write is squashed by pluck/stop so an abandoned update leaves no trace.
  assign w_we    = !pluck && !stop &&
                   ((r_state == FILL_ACC) || (r_state == PLAY_ACC));
  assign w_wdata = (r_state == FILL_ACC) ? r_x : w_avg;
`endif

  // Read address follows idx every cycle, so the word for the current slot
  // is on the read port one clock after the tick is accepted.
  ks_delay_ram #(
    .DATA_W (SAMPLE_W),
    .DEPTH  (MAX_LEN),
    .ADDR_W (LEN_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (w_wdata),
    .i_raddr (r_idx),
    .o_rdata (w_rd_raw)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_len   <= (LEN_W+1)'(2);
      r_x     <= '0;
      r_prev  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef KS_DECAY_EN
      r_avg   <= '0;
      r_decay <= 16'hFFFF;
`endif
    end else begin
      r_valid <= 1'b0;
      if (pluck) begin
        // A tick in the same cycle is ignored; the fill starts on the next one.
        r_len   <= (LEN_W+1)'(clamp_len(int'(period), MAX_LEN));
        r_idx   <= '0;
        r_ovr   <= 1'b0;
        r_state <= FILL_WAIT;
`ifdef KS_DECAY_EN
        r_decay <= decay;
`endif
      end else if (stop) begin
        r_state <= IDLE;
        r_out   <= '0;
      end else begin
        if (sample_tick && w_busy)
          r_ovr <= 1'b1;
        case (r_state)
          FILL_WAIT: begin
            if (sample_tick) begin
              r_x     <= noise_in;
              r_state <= FILL_ACC;
            end
          end
          FILL_ACC: begin
            r_out   <= r_x;
            r_prev  <= r_x;
            r_valid <= 1'b1;
            r_state <= FILL_UPD;
          end
          FILL_UPD: begin
            r_idx   <= w_last ? '0 : r_idx + LEN_W'(1);
            r_state <= w_last ? PLAY_WAIT : FILL_WAIT;
          end
          PLAY_WAIT: begin
            if (sample_tick)
              r_state <= PLAY_ACC;
          end
`ifdef KS_DECAY_EN
          PLAY_ACC: begin
            r_avg   <= w_avg;
            r_prev  <= w_rd;
            r_state <= PLAY_MUL;
          end
          PLAY_MUL: begin
            r_out   <= w_scaled;
            r_valid <= 1'b1;
            r_state <= PLAY_UPD;
          end
`else
          PLAY_ACC: begin
            r_out   <= w_avg;
            r_prev  <= w_rd;
            r_valid <= 1'b1;
            r_state <= PLAY_UPD;
          end
`endif
          PLAY_UPD: begin
            r_idx   <= w_last ? '0 : r_idx + LEN_W'(1);
            r_state <= PLAY_WAIT;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign sample_out   = r_out;
  assign sample_valid = r_valid;
  assign active       = (r_state != IDLE);
  assign overrun      = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_ks_string_synth.sv
// ============================================================================
// Module      : tb_ks_string_synth
// Description : Self-checking bench for ks_string_synth (default build).
//               A behavioural string model (integer array + index) predicts
//               every output sample; directed edge cases plus random plucks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ks_string_synth;

  logic               clk;
  logic               reset_n;
  logic signed [15:0] noise_in;
  logic               sample_tick;
  logic               pluck;
  logic               stop;
  logic [10:0]        period;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               active;
  logic               overrun;

  int n_checks;
  int n_fail;

  // Reference model state
  int m_buf [1024];
  int m_len;
  int m_idx;
  int m_prev;
  bit m_fill;
  bit m_active;

  ks_string_synth dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .noise_in     (noise_in),
    .sample_tick  (sample_tick),
    .pluck        (pluck),
    .stop         (stop),
    .period       (period),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .active       (active),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_half(input int s);
    if (s >= 0)
      return s / 2;
    else
      return -((-s + 1) / 2);
  endfunction

  function automatic void model_pluck(input int p);
    m_len    = (p < 2) ? 2 : ((p > 1024) ? 1024 : p);
    m_idx    = 0;
    m_fill   = 1'b1;
    m_active = 1'b1;
  endfunction

  function automatic int model_tick(input int nz);
    int v;
    int r;
    if (m_fill) begin
      v = nz;
      m_buf[m_idx] = v;
      m_prev = v;
    end else begin
      r = m_buf[m_idx];
      v = floor_half(r + m_prev);
      m_buf[m_idx] = v;
      m_prev = r;
    end
    if (m_idx == m_len - 1) begin
      m_idx  = 0;
      m_fill = 1'b0;
    end else begin
      m_idx++;
    end
    return v;
  endfunction

  // Called at a negedge; returns at a negedge six clocks later.
  task automatic do_tick(input logic signed [15:0] nz);
    int lat;
    int pulses;
    int got;
    int exp;
    lat = -1; pulses = 0; got = 0;
    noise_in    = nz;
    sample_tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) sample_tick = 1'b0;
      if (sample_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          got = int'(sample_out);
        end
      end
    end
    if (m_active) begin
      exp = model_tick(int'(nz));
      chk("latency", lat, 2);
      chk("sample", got, exp);
      chk("pulses", pulses, 1);
    end else begin
      chk("idle_pulses", pulses, 0);
    end
  endtask

  task automatic do_pluck(input int p);
    pluck  = 1'b1;
    period = 11'(p);
    @(negedge clk);
    pluck  = 1'b0;
    model_pluck(p);
    chk("active_after_pluck", int'(active), 1);
    chk("overrun_cleared", int'(overrun), 0);
  endtask

  initial begin
    int pulses;
    int got;
    int p;
    int nt;
    n_checks = 0; n_fail = 0;
    noise_in = '0; sample_tick = 0; pluck = 0; stop = 0; period = '0;
    m_len = 2; m_idx = 0; m_prev = 0; m_fill = 0; m_active = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    @(negedge clk);
    do_tick(16'sd123);   // idle: ignored

    // Constant noise, period 4
    do_pluck(4);
    for (int i = 0; i < 12; i++) do_tick(16'sd1000);

    // Alternating noise, period 4
    do_pluck(4);
    for (int i = 0; i < 4; i++) do_tick((i % 2 == 0) ? 16'sd1000 : -16'sd1000);
    for (int i = 0; i < 8; i++) do_tick(16'($urandom));

    // Floor check, period 2
    do_pluck(2);
    do_tick(-16'sd1);
    do_tick(16'sd0);
    for (int i = 0; i < 3; i++) do_tick(16'($urandom));

    // Clamp low
    do_pluck(0);
    for (int i = 0; i < 6; i++) do_tick(16'($urandom));

    // Clamp high: 1024 fill samples then wrap into play
    do_pluck(2000);
    for (int i = 0; i < 1030; i++) do_tick(16'($urandom));

    // Tick one clock after an accepted tick: dropped, overrun set
    noise_in = 16'($urandom);
    sample_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sample_tick = 1'b0;
    pulses = 0; got = 0;
    if (sample_valid) begin pulses = 1; got = int'(sample_out); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    chk("ovr_sample", got, model_tick(int'(noise_in)));
    chk("ovr_pulses", pulses, 1);
    chk("ovr_flag", int'(overrun), 1);
    do_tick(16'($urandom));

    // Pluck with a tick in the same cycle: tick ignored
    pluck = 1'b1; sample_tick = 1'b1; period = 11'd3; noise_in = 16'sd55;
    @(negedge clk);
    pluck = 1'b0; sample_tick = 1'b0;
    model_pluck(3);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    chk("pluck_tick_pulses", pulses, 0);
    do_tick(16'sd77);

    // Pluck and stop together: pluck wins
    pluck = 1'b1; stop = 1'b1; period = 11'd5;
    @(negedge clk);
    pluck = 1'b0; stop = 1'b0;
    model_pluck(5);
    chk("pluck_stop_active", int'(active), 1);
    do_tick(16'sd900);

    // Stop alone
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    m_active = 1'b0;
    chk("stop_sample_out", int'(sample_out), 0);
    chk("stop_active", int'(active), 0);
    do_tick(16'sd333);
    chk("stop_hold", int'(sample_out), 0);

    // Random plucks
    for (int r = 0; r < 6; r++) begin
      p  = int'($urandom_range(40, 0));
      do_pluck(p);
      nt = ((p < 2) ? 2 : p) + int'($urandom_range(30, 1));
      for (int i = 0; i < nt; i++) do_tick(16'($urandom));
    end

    // Reset mid-play
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_active = 1'b0; m_prev = 0; m_idx = 0; m_len = 2; m_fill = 1'b0;
    chk("mid_rst_sample_out", int'(sample_out), 0);
    chk("mid_rst_active", int'(active), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    do_tick(16'sd4321);
    do_pluck(3);
    for (int i = 0; i < 8; i++) do_tick(16'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
